// File: rtl/rv32i_pkg.sv
// Shared constants and types for the instruction memory and its boot loader.
package rv32i_pkg;

    localparam int unsigned IMEM_WORDS  = 1024;
    localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_WORDS);

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN_LO,
        LDR_LEN_HI,
        LDR_DATA,
        LDR_WRITE,
        LDR_DONE,
        LDR_ERROR
    } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects four accepted bytes into a little-endian 32-bit word.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_c,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    assign last_byte_c  = byte_valid_i && (idx_q == 2'd3);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    // Right shift: the first byte of a word ends up in bits [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= last_byte_c;
            if (clear_i) begin
                idx_q  <= 2'd0;
                word_q <= 32'd0;
            end else if (byte_valid_i) begin
                idx_q  <= idx_q + 2'd1;
                word_q <= {byte_i, word_q[31:8]};
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the core in reset.
module imem_boot_loader
    import rv32i_pkg::*;
#(
    parameter  int unsigned MEM_WORDS = IMEM_WORDS,
    localparam int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    loader_state_e     state_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [CNT_W-1:0]  count_q;
    logic              rx_ready_q;
    logic              core_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic        xfer;
    logic        start_ok;
    logic        last_byte;
    logic [15:0] len_full;

    assign xfer     = rx_valid && rx_ready_q;
    assign start_ok = start && ((state_q == LDR_IDLE) || (state_q == LDR_DONE) || (state_q == LDR_ERROR));
    assign len_full = {rx_data, len_q[7:0]};

    byte_to_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok),
        .byte_valid_i (xfer && (state_q == LDR_DATA)),
        .byte_i       (rx_data),
        .last_byte_c  (last_byte),
        .word_valid_o (mem_we),
        .word_o       (mem_wdata)
    );

    // Outputs are updated together with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LDR_IDLE;
            len_q       <= 16'd0;
            waddr_q     <= '0;
            count_q     <= '0;
            rx_ready_q  <= 1'b0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                    if (start_ok) begin
                        state_q     <= LDR_LEN_LO;
                        waddr_q     <= '0;
                        count_q     <= '0;
                        rx_ready_q  <= 1'b1;
                        core_hold_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                LDR_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= rx_data;
                        state_q    <= LDR_LEN_HI;
                    end
                end
                LDR_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= rx_data;
                        if (len_full == 16'd0) begin
                            state_q     <= LDR_DONE;
                            rx_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else if (len_full > 16'(MEM_WORDS)) begin
                            state_q    <= LDR_ERROR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    if (last_byte) begin
                        state_q    <= LDR_WRITE;
                        rx_ready_q <= 1'b0;
                    end
                end
                LDR_WRITE: begin
                    count_q <= count_q + CNT_W'(1);
                    waddr_q <= waddr_q + ADDR_W'(1);
                    if (16'(count_q) + 16'd1 == len_q) begin
                        state_q     <= LDR_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        core_hold_q <= 1'b0;
                    end else begin
                        state_q    <= LDR_DATA;
                        rx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= LDR_IDLE;
                    rx_ready_q  <= 1'b0;
                    core_hold_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready      = rx_ready_q;
    assign mem_waddr     = waddr_q;
    assign core_hold     = core_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for the boot loader: expected memory writes are queued as bytes are sent.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_written;

    imem_boot_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .core_hold     (core_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_addr = -1;
    logic [41:0] sb[$];
    logic [31:0] wbuf [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every observed write must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 32'(mem_waddr), 32'hFFFF_FFFF);
            end else begin
                logic [41:0] e;
                e = sb.pop_front();
                check_eq("waddr", 32'(mem_waddr), 32'(e[41:32]));
                check_eq("wdata", mem_wdata, e[31:0]);
                last_addr = int'(mem_waddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("rx_ready_timeout", 32'd0, 32'd1);
        tick();
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Sends the length header and nwords words from wbuf; returns right after the last accept.
    task automatic run_load(input logic [15:0] n_field, input int nwords, input int gap_max);
        logic [31:0] w;
        send_byte(n_field[7:0], 0);
        send_byte(n_field[15:8], 0);
        for (int i = 0; i < nwords; i++) begin
            w = wbuf[i];
            sb.push_back({10'(i), w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
            end
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int first_acc;
        logic [31:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;

        check_eq("rst_core_hold", 32'(core_hold), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_waddr", 32'(mem_waddr), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_words", 32'(words_written), 32'd0);
        rx_valid = 1'b1;
        repeat (10) tick();
        rx_valid = 1'b0;
        check_eq("idle_core_hold", 32'(core_hold), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);

        // Two words back to back, rx_valid held high through the write cycles
        pulse_start();
        check_eq("load_busy", 32'(busy), 32'd1);
        check_eq("load_rx_ready", 32'(rx_ready), 32'd1);
        wbuf[0] = 32'h0000_0013;
        wbuf[1] = 32'h0000_006F;
        send_byte(8'h02, 0);
        first_acc = cyc;
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            w = wbuf[i];
            sb.push_back({10'(i), w});
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        end
        rx_valid = 1'b0;
        check_eq("two_done_early", 32'(done), 32'd0);
        tick();
        check_eq("two_latency", 32'(cyc - first_acc + 1), 32'd12);
        check_eq("two_done", 32'(done), 32'd1);
        check_eq("two_core_hold", 32'(core_hold), 32'd0);
        check_eq("two_busy", 32'(busy), 32'd0);
        check_eq("two_words", 32'(words_written), 32'd2);

        // Zero-length image
        pulse_start();
        check_eq("zero_done_cleared", 32'(done), 32'd0);
        run_load(16'd0, 0, 0);
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_core_hold", 32'(core_hold), 32'd0);
        check_eq("zero_words", 32'(words_written), 32'd0);
        check_eq("zero_rx_ready", 32'(rx_ready), 32'd0);

        // Length one past capacity is rejected
        pulse_start();
        run_load(16'd1025, 0, 0);
        check_eq("big_error", 32'(error), 32'd1);
        check_eq("big_done", 32'(done), 32'd0);
        check_eq("big_core_hold", 32'(core_hold), 32'd1);
        check_eq("big_busy", 32'(busy), 32'd0);
        check_eq("big_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        repeat (5) tick();
        rx_valid = 1'b0;
        check_eq("big_error_sticky", 32'(error), 32'd1);

        // Full memory image
        for (int i = 0; i < 1024; i++) wbuf[i] = $urandom;
        pulse_start();
        check_eq("full_error_cleared", 32'(error), 32'd0);
        run_load(16'd1024, 1024, 0);
        tick();
        check_eq("full_done", 32'(done), 32'd1);
        check_eq("full_words", 32'(words_written), 32'd1024);
        check_eq("full_last_addr", 32'(last_addr), 32'd1023);
        check_eq("full_core_hold", 32'(core_hold), 32'd0);

        // Random rx_valid gaps
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        pulse_start();
        run_load(16'd3, 3, 3);
        tick();
        check_eq("gap_done", 32'(done), 32'd1);
        check_eq("gap_words", 32'(words_written), 32'd3);
        check_eq("gap_last_addr", 32'(last_addr), 32'd2);

        // Reset after six payload bytes of a two-word load
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        w = 32'h4433_2211;
        sb.push_back({10'd0, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rx_valid = 1'b0;
        check_eq("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_core_hold", 32'(core_hold), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("mid_idle_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("mid_idle_done", 32'(done), 32'd0);
        wbuf[0] = 32'hDDCC_BBAA;
        pulse_start();
        run_load(16'd1, 1, 0);
        tick();
        check_eq("restart_done", 32'(done), 32'd1);
        check_eq("restart_words", 32'(words_written), 32'd1);
        check_eq("restart_last_addr", 32'(last_addr), 32'd0);

        repeat (3) tick();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
